led_bank_pwm: RTL and testbench

LED_BANK_PWM -- requirements
Module: led_bank_pwm

---
 rtl/led_bank_pkg.sv | 17 +
 rtl/led_dimmer.sv | 54 +++++
 rtl/led_bank_pwm.sv | 95 +++++++++
 tb/tb_led_bank_pwm.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/led_bank_pkg.sv
// Shared opcodes and state encoding for the LED bank.
// Imported by led_bank_pwm and led_dimmer.
package led_bank_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDH = 4'h2;
  localparam logic [3:0] OP_LDB = 4'h3;
  localparam logic [3:0] OP_BRT = 4'h4;
  localparam logic [3:0] OP_BLK = 4'h5;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_ERROR = 1'b1
  } state_e;

endpackage

// File: rtl/led_dimmer.sv
// PWM counter, blink prescaler and blink phase.
// Ports: clock, reset (async low), duty, blink_en, restart -> gate.
module led_dimmer
  import led_bank_pkg::*;
#(
  parameter int PWM_BITS   = 4,
  parameter int BLINK_BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                blink_en,
  input  logic                restart,
  output logic                gate
);

  localparam logic [PWM_BITS-1:0]   PWM_ONE = 1;
  localparam logic [BLINK_BITS-1:0] BLK_ONE = 1;

  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;
  logic                  pwm_on;

  always_comb begin
    pwm_cnt_d   = pwm_cnt_q + PWM_ONE;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (restart || !blink_en) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else begin
      blink_cnt_d = blink_cnt_q + BLK_ONE;
      if (&blink_cnt_q) phase_d = ~phase_q;
    end
  end

  // all-ones duty means fully on, not 15/16
  assign pwm_on = (pwm_cnt_q < duty) || (&duty);
  assign gate   = pwm_on & phase_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

endmodule

// File: rtl/led_bank_pwm.sv
// LED bank: instruction decode, pattern, READY/ERROR FSM, LED register.
// Ports: clock, reset (async low), inst[11:0], inst_en -> leds, error.
module led_bank_pwm
  import led_bank_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int PWM_BITS   = 4,
  parameter int BLINK_BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [11:0]         inst,
  input  logic                inst_en,
  output logic [NUM_LEDS-1:0] leds,
  output logic                error
);

  state_e                state_q, state_d;
  logic [NUM_LEDS-1:0]   pattern_q, pattern_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic                  blink_en_q, blink_en_d;
  logic [NUM_LEDS-1:0]   leds_q, leds_d;
  logic [15:0]           pat16;
  logic [3:0]            op;
  logic [7:0]            imm;
  logic [3:0]            idx;
  logic                  restart;
  logic                  gate;

  assign op  = inst[11:8];
  assign imm = inst[7:0];
  assign idx = imm[7:4];

  always_comb begin
    state_d    = state_q;
    pat16      = 16'(pattern_q);
    duty_d     = duty_q;
    blink_en_d = blink_en_q;
    restart    = 1'b0;
    if (inst_en && state_q == ST_READY) begin
      unique case (1'b1)
        op == OP_NOP: ;
        op == OP_LDI: pat16[7:0] = imm;
        op == OP_LDH: pat16[15:8] = imm;
        op == OP_LDB: begin
          if (32'(idx) < NUM_LEDS) pat16[idx] = imm[0];
          else state_d = ST_ERROR;
        end
        op == OP_BRT: duty_d = imm[PWM_BITS-1:0];
        op == OP_BLK: begin
          blink_en_d = imm[0];
          restart    = imm[0] & ~blink_en_q;
        end
        default: state_d = ST_ERROR;
      endcase
    end
    // bits above NUM_LEDS fall off here
    pattern_d = pat16[NUM_LEDS-1:0];
    leds_d    = '0;
    if (state_q == ST_READY)
      leds_d = pattern_q & {NUM_LEDS{gate}};
  end

  led_dimmer #(
    .PWM_BITS   (PWM_BITS),
    .BLINK_BITS (BLINK_BITS)
  ) u_dimmer (
    .clock    (clock),
    .reset    (reset),
    .duty     (duty_q),
    .blink_en (blink_en_d),
    .restart  (restart),
    .gate     (gate)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_READY;
      pattern_q  <= '0;
      duty_q     <= '1;
      blink_en_q <= 1'b0;
      leds_q     <= '0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      duty_q     <= duty_d;
      blink_en_q <= blink_en_d;
      leds_q     <= leds_d;
    end
  end

  assign leds  = leds_q;
  assign error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_led_bank_pwm.sv
// Directed bench for led_bank_pwm (8-LED and 12-LED instances).
module tb_led_bank_pwm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] inst8, inst12;
  logic        en8, en12;
  logic [7:0]  leds8;
  logic [11:0] leds12;
  logic        err8, err12;

  int tests = 0;
  int fails = 0;
  int n_on, n_off;

  always #5 clk = ~clk;

  led_bank_pwm dut8 (
    .clock   (clk),
    .reset   (rst_n),
    .inst    (inst8),
    .inst_en (en8),
    .leds    (leds8),
    .error   (err8)
  );

  led_bank_pwm #(.NUM_LEDS(12)) dut12 (
    .clock   (clk),
    .reset   (rst_n),
    .inst    (inst12),
    .inst_en (en12),
    .leds    (leds12),
    .error   (err12)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [3:0] op, input logic [7:0] imm);
    @(negedge clk);
    inst8 = {op, imm};
    en8   = 1'b1;
    @(posedge clk);
    #1;
    en8   = 1'b0;
    inst8 = 'x;
  endtask

  task automatic send12(input logic [3:0] op, input logic [7:0] imm);
    @(negedge clk);
    inst12 = {op, imm};
    en12   = 1'b1;
    @(posedge clk);
    #1;
    en12   = 1'b0;
    inst12 = 'x;
  endtask

  // count cycles over a 16-cycle window where leds8 equals val
  task automatic count16(input logic [7:0] val, output int n);
    n = 0;
    repeat (16) begin
      tick();
      if (leds8 === val) n++;
    end
  endtask

  initial begin
    // reset held while an instruction is presented
    rst_n  = 1'b0;
    inst8  = 12'h1FF;
    en8    = 1'b1;
    inst12 = 12'h0;
    en12   = 1'b0;
    tick();
    tick();
    chk("rst_leds", 16'(leds8), 16'h00);
    chk("rst_err", 16'(err8), 16'h0);
    chk("rst_leds12", 16'(leds12), 16'h000);
    @(negedge clk);
    en8   = 1'b0;
    inst8 = 'x;
    rst_n = 1'b1;
    tick();
    chk("rst_prio", 16'(leds8), 16'h00);

    // LDI latency: visible one edge after the LDI edge
    send8(4'h1, 8'hD7);
    chk("ldi_lat", 16'(leds8), 16'h00);
    tick();
    chk("ldi_d7", 16'(leds8), 16'hD7);
    chk("ldi_err", 16'(err8), 16'h0);

    // inst ignored (X) while inst_en low
    repeat (3) tick();
    chk("idle_x", 16'(leds8), 16'hD7);

    // LDB sets, out-of-range LDB faults
    send8(4'h1, 8'h00);
    send8(4'h3, 8'h31);
    send8(4'h3, 8'h51);
    tick();
    chk("ldb_28", 16'(leds8), 16'h28);
    send8(4'h3, 8'h90);
    chk("ldb90_err", 16'(err8), 16'h1);
    tick();
    chk("ldb90_leds", 16'(leds8), 16'h00);
    send8(4'h1, 8'hFF);
    tick();
    tick();
    chk("err_ign_leds", 16'(leds8), 16'h00);
    chk("err_sticky", 16'(err8), 16'h1);

    // asynchronous reset clears error without a clock edge
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_err", 16'(err8), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // PWM duty
    send8(4'h1, 8'hFF);
    send8(4'h4, 8'h04);
    tick();
    count16(8'hFF, n_on);
    chk("pwm4_on", 16'(n_on), 16'd4);
    count16(8'h00, n_off);
    chk("pwm4_off", 16'(n_off), 16'd12);
    send8(4'h4, 8'h0F);
    tick();
    count16(8'hFF, n_on);
    chk("pwm15_on", 16'(n_on), 16'd16);
    send8(4'h4, 8'h00);
    tick();
    count16(8'h00, n_off);
    chk("pwm0_off", 16'(n_off), 16'd16);

    // blink: 16 on, 16 off
    send8(4'h4, 8'h0F);
    send8(4'h1, 8'hA5);
    send8(4'h5, 8'h01);
    count16(8'hA5, n_on);
    chk("blink_on", 16'(n_on), 16'd16);
    count16(8'h00, n_off);
    chk("blink_off", 16'(n_off), 16'd16);
    count16(8'hA5, n_on);
    chk("blink_on2", 16'(n_on), 16'd16);
    send8(4'h5, 8'h00);
    tick();
    count16(8'hA5, n_on);
    chk("blink_stop", 16'(n_on), 16'd16);

    // illegal opcode mid-blink, then reset and reload
    send8(4'h5, 8'h01);
    repeat (20) tick();
    send8(4'hE, 8'hAA);
    chk("opE_err", 16'(err8), 16'h1);
    tick();
    chk("opE_leds", 16'(leds8), 16'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_leds", 16'(leds8), 16'h00);
    chk("rst2_err", 16'(err8), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send8(4'h1, 8'h25);
    tick();
    chk("post_rst_25", 16'(leds8), 16'h25);
    count16(8'h25, n_on);
    chk("post_rst_steady", 16'(n_on), 16'd16);

    // LDH on 8 LEDs is discarded silently
    send8(4'h2, 8'hFF);
    tick();
    chk("ldh8_leds", 16'(leds8), 16'h25);
    chk("ldh8_err", 16'(err8), 16'h0);

    // 12-LED instance
    send12(4'h1, 8'h34);
    send12(4'h2, 8'hF2);
    tick();
    chk("n12_234", 16'(leds12), 16'h234);
    send12(4'h3, 8'hB1);
    tick();
    chk("n12_a34", 16'(leds12), 16'hA34);
    chk("n12_ok", 16'(err12), 16'h0);
    send12(4'h3, 8'hC1);
    chk("n12_err", 16'(err12), 16'h1);
    tick();
    chk("n12_off", 16'(leds12), 16'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
